// File: rtl/arb_pkg.sv
// Shared types and helpers for the 16-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned ID_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Mask with bits 0..ptr set; selects the requesters still ahead in rotation.
    function automatic logic [N_REQ-1:0] low_mask(input logic [ID_W-1:0] ptr);
        logic [N_REQ-1:0] m;
        m = '0;
        for (int i = 0; i < N_REQ; i++) begin
            m[i] = (ID_W'(i) <= ptr);
        end
        return m;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// 16:1 priority encoder: index of the highest set bit, plus any-bit-set flag.
module prio_enc16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] d,
    output logic [ID_W-1:0]  y,
    output logic             valid
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (d[i]) begin
                y = ID_W'(i);
            end
        end
    end

    assign valid = |d;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters: latches one owner, holds until release,
// request drop or hold timeout, then rotates priority past the last winner.
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_d;
    logic [ID_W-1:0]  gnt_id_d;
    logic             gnt_valid_d;
    logic             timeout_d;

    logic [N_REQ-1:0] masked_req;
    logic [ID_W-1:0]  masked_id, full_id, winner;
    logic             masked_any, full_any;
    logic             release_c, expire_c;

    assign masked_req = req & low_mask(ptr_q);

    prio_enc16 u_enc_masked (
        .d     (masked_req),
        .y     (masked_id),
        .valid (masked_any)
    );

    prio_enc16 u_enc_full (
        .d     (req),
        .y     (full_id),
        .valid (full_any)
    );

    // Fall back to the unmasked search when nothing remains below the pointer.
    assign winner    = masked_any ? masked_id : full_id;
    assign release_c = rel | ~req[gnt_id];
    assign expire_c  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (full_any) begin
                    state_d     = ST_GRANT;
                    gnt_id_d    = winner;
                    gnt_d       = N_REQ'(1) << winner;
                    gnt_valid_d = 1'b1;
                    cnt_d       = CNT_W'(1);
                    ptr_d       = ID_W'(winner - ID_W'(1));
                end
            end
            ST_GRANT: begin
                if (release_c || expire_c) begin
                    state_d     = ST_IDLE;
                    gnt_id_d    = '0;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    // An explicit or implicit release wins over a coincident expiry.
                    timeout_d   = expire_c & ~release_c;
                end else if ((MAX_HOLD != 0) && (cnt_q != CNT_W'(MAX_HOLD))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= ID_W'(N_REQ - 1);
            cnt_q     <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
        end
    end

endmodule
